pipe_stall_ctrl: RTL

//  Central pipeline controller for the 6-slot stall vector (PC,IF,ID,EX,MEM,WB) that drives every pipe_* stage register.

---
 rtl/pipe_stall_ctrl_pkg.sv | 40 ++++
 rtl/pipe_stall_ctrl_if.sv | 48 ++++
 rtl/pipe_stall_ctrl_watchdog.sv | 48 ++++
 rtl/pipe_stall_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and encodings for the pipeline stall/flush controller.
// Stall vectors are ordered PC, IF, ID, EX, MEM, WB from bit 0 upward.
package pipe_stall_ctrl_pkg;

    localparam int REG_W   = 32;
    localparam int STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic mem;
        logic ex;
        logic id;
        logic fetch;
    } stall_req_t;

    // The deepest requesting stage wins; it also holds every stage upstream of it.
    function automatic logic [STALL_W-1:0] stall_encode(stall_req_t req);
        logic [STALL_W-1:0] s;
        s = STALL_NONE;
        priority case (1'b1)
            req.mem:   s = STALL_MEM;
            req.ex:    s = STALL_EX;
            req.id:    s = STALL_ID;
            req.fetch: s = STALL_IF;
            default:   s = STALL_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall controller.
// The pipeline side is master; the controller is slave.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_stall_ctrl_pkg::*;

    logic               stallreq_if;
    logic               stallreq_id;
    logic               stallreq_ex;
    logic               stallreq_mem;
    logic               flush_req;
    logic [REG_W-1:0]   flush_pc;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [REG_W-1:0]   new_pc;
    logic               stall_timeout;
    logic [CNT_W-1:0]   stall_cycles;

    modport master (
        output stallreq_if,
        output stallreq_id,
        output stallreq_ex,
        output stallreq_mem,
        output flush_req,
        output flush_pc,
        input  stall,
        input  flush,
        input  new_pc,
        input  stall_timeout,
        input  stall_cycles
    );

    modport slave (
        input  stallreq_if,
        input  stallreq_id,
        input  stallreq_ex,
        input  stallreq_mem,
        input  flush_req,
        input  flush_pc,
        output stall,
        output flush,
        output new_pc,
        output stall_timeout,
        output stall_cycles
    );

endinterface

// File: rtl/pipe_stall_ctrl_watchdog.sv
// Stall-duration watchdog with sticky timeout flag and a saturating
// performance counter of stalled cycles.
module pipe_stall_ctrl_watchdog #(
    parameter int WDT_LIMIT = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_any,
    input  logic             in_flush,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles
);

    localparam int WCNT_W = $clog2(WDT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WDT_MAX = WCNT_W'(WDT_LIMIT);

    logic [WCNT_W-1:0] wcnt;
    logic              counting;

    assign counting = stall_any && !in_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            if (!counting) begin
                wcnt <= '0;
            end else if (wcnt != WDT_MAX) begin
                wcnt <= wcnt + 1'b1;
            end
            // Flag on the cycle the count reaches the limit, then stick.
            if (counting && (wcnt == WDT_MAX - 1'b1)) begin
                timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles <= '0;
        end else if (stall_any && (cycles != '1)) begin
            cycles <= cycles + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: merges per-stage stall requests and
// redirect requests into the stall vector, flush and new_pc.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int WDT_LIMIT    = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave bus
);

    localparam int FCNT_W = 2;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_e        state;
    ctrl_state_e        state_nxt;
    logic [FCNT_W-1:0]  fcnt;
    logic [FCNT_W-1:0]  fcnt_nxt;
    logic [REG_W-1:0]   new_pc;
    logic [REG_W-1:0]   new_pc_nxt;
    stall_req_t         req;
    logic [STALL_W-1:0] stall;
    logic               in_flush;

    assign req = '{
        mem:   bus.stallreq_mem,
        ex:    bus.stallreq_ex,
        id:    bus.stallreq_id,
        fetch: bus.stallreq_if
    };

    assign in_flush = (state == CTRL_FLUSH);

    // Masked during reset and flush so a stall never holds a stage being cleared.
    assign stall = (!rst || in_flush) ? STALL_NONE : stall_encode(req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= CTRL_RUN;
            fcnt   <= '0;
            new_pc <= '0;
        end else begin
            state  <= state_nxt;
            fcnt   <= fcnt_nxt;
            new_pc <= new_pc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        fcnt_nxt   = fcnt;
        new_pc_nxt = new_pc;
        unique case (state)
            CTRL_RUN: begin
                if (bus.flush_req) begin
                    state_nxt  = CTRL_FLUSH;
                    fcnt_nxt   = '0;
                    new_pc_nxt = bus.flush_pc;
                end
            end
            CTRL_FLUSH: begin
                // A newer redirect restarts the window and replaces the target.
                if (bus.flush_req) begin
                    fcnt_nxt   = '0;
                    new_pc_nxt = bus.flush_pc;
                end else if (fcnt == FCNT_LAST) begin
                    state_nxt = CTRL_RUN;
                    fcnt_nxt  = '0;
                end else begin
                    fcnt_nxt = fcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = CTRL_RUN;
                fcnt_nxt  = '0;
            end
        endcase
    end

    pipe_stall_ctrl_watchdog #(
        .WDT_LIMIT (WDT_LIMIT),
        .CNT_W     (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .stall_any (|stall),
        .in_flush  (in_flush),
        .timeout   (bus.stall_timeout),
        .cycles    (bus.stall_cycles)
    );

    assign bus.stall  = stall;
    assign bus.flush  = in_flush;
    assign bus.new_pc = new_pc;

endmodule
